// File: rtl/phase_capture.sv
// Timestamps rising edges of sig_in against a free-running divided reference counter.
// Define SIG_DEGLITCH_EN to insert a 3-cycle-stable filter ahead of edge detection.
module phase_capture #(
  parameter int OFFSET_WIDTH = 11,
  parameter int LOST_PERIODS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sig_in,
  input  logic                    enable,
  input  logic [OFFSET_WIDTH-2:0] divide,
  output logic [OFFSET_WIDTH-1:0] phase,
  output logic                    phase_valid,
  input  logic                    phase_ready,
  output logic                    lost,
  output logic                    overrun
);

  localparam int CW = OFFSET_WIDTH - 1;
  localparam int LW = $clog2(2 * LOST_PERIODS + 1);
  localparam logic [LW-1:0] LOSS_MAX = LW'(2 * LOST_PERIODS);
  localparam logic [LW-1:0] LOSS_PRE = LW'(2 * LOST_PERIODS - 1);

  logic [CW-1:0] r_cnt;
  logic          r_half;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic          r_edge;
  logic [LW-1:0] r_lossCnt;
  logic          w_toggle;
  logic          w_src;
  logic          w_edge;

  // >= rather than == so a divide lowered below cnt wraps at once instead of rolling over
  assign w_toggle = enable && (r_cnt >= divide);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (r_cnt >= divide) begin
      r_cnt  <= '0;
      r_half <= ~r_half;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef SIG_DEGLITCH_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
    end
  end

  // r_prev doubles as the filter output: it only follows sig_s after three equal samples
  always_comb begin
    w_src = r_prev;
    if (r_sync2 && (&r_hist)) begin
      w_src = 1'b1;
    end else if (!r_sync2 && !(|r_hist)) begin
      w_src = 1'b0;
    end
  end
`else
  assign w_src = r_sync2;
`endif

  assign w_edge = w_src & ~r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= w_src;
      r_edge  <= w_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= '0;
      phase_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (enable) begin
      if (r_edge) begin
        if (!phase_valid || phase_ready) begin
          phase       <= {r_half, r_cnt};
          phase_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (phase_valid && phase_ready) begin
        phase_valid <= 1'b0;
      end
    end
  end

  // Edge clear wins over a coincident half toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lossCnt <= '0;
      lost      <= 1'b0;
    end else if (enable) begin
      if (r_edge) begin
        r_lossCnt <= '0;
        lost      <= 1'b0;
      end else if (w_toggle && (r_lossCnt != LOSS_MAX)) begin
        r_lossCnt <= r_lossCnt + 1'b1;
        lost      <= (r_lossCnt == LOSS_PRE);
      end
    end
  end

endmodule

// File: tb/tb_phase_capture.sv
// Self-checking bench for phase_capture: randomized directed steps against an
// arithmetic reference of the reference counter and loss-of-signal rule.
module tb_phase_capture;

  localparam int OW = 11;
  localparam int LP = 4;
`ifdef SIG_DEGLITCH_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sigIn;
  logic          enable;
  logic [OW-2:0] divide;
  logic [OW-1:0] phase;
  logic          phaseValid;
  logic          phaseReady;
  logic          lost;
  logic          overrun;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int D;
  int E0;
  int lastEvt;
  int pendEvt;
  bit lostChk;

  phase_capture #(.OFFSET_WIDTH(OW), .LOST_PERIODS(LP)) dut (
    .clk(clk),
    .rst(rst),
    .sig_in(sigIn),
    .enable(enable),
    .divide(divide),
    .phase(phase),
    .phase_valid(phaseValid),
    .phase_ready(phaseReady),
    .lost(lost),
    .overrun(overrun)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Half toggles that occurred at posedges up to and including edge x of the current segment
  function automatic int togUpTo(input int x);
    return (x - E0 + 1) / (D + 1);
  endfunction

  // Reference word after n counter steps from the zero state with constant divide D
  function automatic logic [OW-1:0] expPhase(input int n);
    logic [OW-1:0] v;
    v = OW'(n % (D + 1));
    v[OW-1] = ((n / (D + 1)) % 2) == 1;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (pendEvt >= 0 && cyc >= pendEvt) begin
      lastEvt = pendEvt;
      pendEvt = -1;
    end
    if (lostChk) begin
      checkOutput("lost", 32'(lost), 32'((togUpTo(cyc) - togUpTo(lastEvt)) >= 2 * LP));
    end
  endtask

  task automatic doReset();
    lostChk = 1'b0;
    rst = 1'b1;
    enable = 1'b0;
    sigIn = 1'b0;
    phaseReady = 1'b1;
    step();
    step();
    checkOutput("rstPhase", 32'(phase), 32'd0);
    checkOutput("rstValid", 32'(phaseValid), 32'd0);
    checkOutput("rstLost", 32'(lost), 32'd0);
    checkOutput("rstOverrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    step();
  endtask

  task automatic startSeg(input int d);
    D = d;
    divide = (OW-1)'(d);
    enable = 1'b1;
    E0 = cyc + 1;
    lastEvt = E0 - 1;
    pendEvt = -1;
    lostChk = 1'b1;
    step();
  endtask

  // Raises sigIn now; returns once the capture (if taken) is visible on the outputs
  task automatic fire(output logic [OW-1:0] e);
    int c;
    c = cyc;
    e = expPhase(c + LAT - E0 + 1);
    sigIn = 1'b1;
    pendEvt = c + 1 + LAT;
    repeat (LAT + 1) step();
  endtask

  task automatic settle();
    step();
    sigIn = 1'b0;
    repeat (LAT + 3) step();
  endtask

  // One edge with phaseReady=1 and no pending capture: latency, value and consumption
  task automatic applyStimulus(input string tag);
    int c;
    logic [OW-1:0] e;
    c = cyc;
    e = expPhase(c + LAT - E0 + 1);
    sigIn = 1'b1;
    pendEvt = c + 1 + LAT;
    repeat (LAT) step();
    checkOutput({tag, "_pre"}, 32'(phaseValid), 32'd0);
    step();
    checkOutput({tag, "_valid"}, 32'(phaseValid), 32'd1);
    checkOutput({tag, "_phase"}, 32'(phase), 32'(e));
    step();
    sigIn = 1'b0;
    checkOutput({tag, "_taken"}, 32'(phaseValid), 32'd0);
    repeat (LAT + 3) step();
  endtask

  initial begin
    #(20 * 60000);
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [OW-1:0] e1;
    logic [OW-1:0] e2;
    rst = 1'b1; sigIn = 1'b0; enable = 1'b0; divide = '0; phaseReady = 1'b1;
    lostChk = 1'b0; pendEvt = -1; D = 0; E0 = 0; lastEvt = 0;
    doReset();

    // 40 kHz input aligned with the start of the low half, then shifted by half a period
    startSeg(624);
    for (int k = 1; k <= 3; k++) begin
      while (cyc < E0 - 2 + 1250 * k) step();
      applyStimulus("inPhase");
      checkOutput("inPhaseWord", 32'(phase), 32'(LAT - 1));
    end
    for (int k = 4; k <= 5; k++) begin
      while (cyc < E0 - 2 + 1250 * k + 625) step();
      applyStimulus("delayed");
      checkOutput("delayedWord", 32'(phase), 32'((1 << (OW - 1)) | (LAT - 1)));
    end
    checkOutput("alignedOverrun", 32'(overrun), 32'd0);

    // divide lowered below the running count
    doReset();
    startSeg(624);
    lostChk = 1'b0;
    while (cyc < E0 + 499) step();
    divide = 10'd99;
    fire(e1);
    checkOutput("divDropValid", 32'(phaseValid), 32'd1);
    checkOutput("divDropPhase", 32'(phase), 32'((1 << (OW - 1)) | (LAT - 1)));
    settle();

    // divide = 0
    doReset();
    startSeg(0);
    repeat (3) step();
    applyStimulus("div0");

    // Loss of signal with divide = 9
    doReset();
    startSeg(9);
    repeat (5) step();
    applyStimulus("lossA");
    while (cyc < lastEvt + 120) step();
    checkOutput("lostSet", 32'(lost), 32'd1);
    applyStimulus("lossB");
    checkOutput("lostClr", 32'(lost), 32'd0);

    // Back-pressure: second capture dropped, then consumed by a one-cycle ready
    doReset();
    startSeg($urandom_range(50, 400));
    phaseReady = 1'b0;
    fire(e1);
    checkOutput("bpValid", 32'(phaseValid), 32'd1);
    checkOutput("bpPhase", 32'(phase), 32'(e1));
    settle();
    checkOutput("bpNoOverrun", 32'(overrun), 32'd0);
    fire(e2);
    checkOutput("bpOverrun", 32'(overrun), 32'd1);
    checkOutput("bpHeld", 32'(phase), 32'(e1));
    settle();
    phaseReady = 1'b1;
    step();
    phaseReady = 1'b0;
    checkOutput("bpConsumed", 32'(phaseValid), 32'd0);
    checkOutput("bpPhaseKept", 32'(phase), 32'(e1));
    checkOutput("bpSticky", 32'(overrun), 32'd1);

    // Capture coinciding with consumption of the previous word
    doReset();
    startSeg($urandom_range(50, 400));
    phaseReady = 1'b0;
    fire(e1);
    settle();
    begin
      int c;
      c = cyc;
      e2 = expPhase(c + LAT - E0 + 1);
      sigIn = 1'b1;
      pendEvt = c + 1 + LAT;
      repeat (LAT) step();
      phaseReady = 1'b1;
      step();
      phaseReady = 1'b0;
    end
    checkOutput("swapValid", 32'(phaseValid), 32'd1);
    checkOutput("swapPhase", 32'(phase), 32'(e2));
    checkOutput("swapOverrun", 32'(overrun), 32'd0);
    settle();

    // enable=0 freezes the handshake; reset then discards the pending word
    lostChk = 1'b0;
    enable = 1'b0;
    phaseReady = 1'b1;
    repeat (3) step();
    checkOutput("disValid", 32'(phaseValid), 32'd1);
    checkOutput("disPhase", 32'(phase), 32'(e2));
    doReset();

`ifdef SIG_DEGLITCH_EN
    startSeg(200);
    sigIn = 1'b1;
    step();
    step();
    sigIn = 1'b0;
    repeat (12) step();
    checkOutput("glitchReject", 32'(phaseValid), 32'd0);
    applyStimulus("stableRise");
    doReset();
`endif

    for (int s = 0; s < 4; s++) begin
      doReset();
      startSeg($urandom_range(1, 1023));
      for (int p = 0; p < 3; p++) begin
        repeat ($urandom_range(1, 1500)) step();
        applyStimulus("rand");
      end
      checkOutput("randOverrun", 32'(overrun), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_capture.md
PHASE_CAPTURE -- requirements
Module: phase_capture

Interface
REQ-001 Parameter OFFSET_WIDTH, default 11: width of the captured phase word, 1 half-period bit plus OFFSET_WIDTH-1 count bits.
REQ-002 Parameter LOST_PERIODS, default 4: number of full reference periods with no input edge before loss of signal is flagged.
REQ-003 clk  input  1  system clock, 50 MHz; one clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sig_in  input  1  asynchronous square wave from the receive-transducer comparator.
REQ-006 enable  input  1  1 = reference counter runs; 0 = counter held at zero, no captures.
REQ-007 divide  input  OFFSET_WIDTH-1  half-period terminal count; half period = divide+1 cycles.
REQ-008 phase  output  OFFSET_WIDTH  captured phase {half, cnt}.
REQ-009 phase_valid  output  1  phase holds an unconsumed capture.
REQ-010 phase_ready  input  1  consumer accepts phase when phase_valid is also 1.
REQ-011 lost  output  1  no rising edge seen for LOST_PERIODS full periods.
REQ-012 overrun  output  1  sticky: a capture was dropped because phase_valid was still set.

Function
REQ-013 Reference counter cnt (OFFSET_WIDTH-1 bits) and half bit: when enable=1 and cnt>=divide, cnt<=0 and half<=~half; otherwise cnt<=cnt+1.
REQ-014 The >= compare handles divide lowered mid-run below cnt: wrap occurs on the next cycle, never a roll past the maximum value.
REQ-015 divide=0: half toggles every cycle and cnt stays 0.
REQ-016 enable=0: cnt<=0, half<=0, no capture, no change to the lost counter; phase, phase_valid, lost and overrun hold.
REQ-017 sig_in passes through a 2-flop synchronizer to sig_s; a rising edge event is sig_s=1 with the previous sig_s=0.
REQ-018 On an edge event with enable=1, the current {half, cnt} is the capture value. phase is not latency-compensated.
REQ-019 Fixed latency from a sig_in rising edge (setup met at clock edge N) to the capture sample: 2 cycles; phase/phase_valid update at edge N+3.
REQ-020 Output buffer: on a capture with phase_valid=0, phase<=capture and phase_valid<=1.
REQ-021 phase_valid=1 and phase_ready=1 with no capture: phase_valid<=0 and phase holds.
REQ-022 Capture in the same cycle as phase_valid&&phase_ready: the new value is loaded, phase_valid stays 1, no overrun.
REQ-023 Capture while phase_valid=1 and phase_ready=0: capture is dropped, phase unchanged, overrun<=1; overrun clears only on rst.
REQ-024 phase stays stable while phase_valid=1 and the capture is not accepted.
REQ-025 Loss counter counts half toggles since the last edge event and saturates at 2*LOST_PERIODS; lost=1 while the count equals 2*LOST_PERIODS.
REQ-026 An edge event clears the loss counter and deasserts lost in the same update.
REQ-027 An edge event coinciding with a half toggle clears the counter; the clear has priority.

Reset
REQ-028 rst=1 at a clock edge: cnt=0, half=0, synchronizer and filter flops=0, phase=0, phase_valid=0, overrun=0, loss counter=0, lost=0.
REQ-029 rst has priority over every other input; asserting it mid-handshake discards the pending capture.
REQ-030 First edge event possible no earlier than the 3rd cycle after rst deasserts.

Configuration
REQ-031 Macro SIG_DEGLITCH_EN defined: a filter between sig_s and edge detection updates its output only after sig_s has held one value for 3 consecutive cycles.
REQ-032 With SIG_DEGLITCH_EN, pulses of 1-2 cycles are rejected and the REQ-019 latency becomes 4 cycles (update at edge N+5).
REQ-033 Macro SIG_DEGLITCH_EN undefined: no filter; edges are detected on sig_s directly with 2-cycle latency.

Verification
REQ-034 divide=624, enable=1, phase_ready=1, 40 kHz sig_in in phase with half, every edge at cnt=0 with half=0 -> every capture phase=0x002 (cnt=2, half=0), overrun=0.
REQ-035 Same stimulus, sig_in delayed 625 cycles -> phase=0x402 (half=1, cnt=2).
REQ-036 phase_ready=0, two sig_in edges -> first capture held in phase, overrun=1; phase_ready=1 for one cycle -> phase_valid=0.
REQ-037 divide=9, sig_in stuck at 0 -> lost=1 exactly 8 half toggles (80 cycles) after the last edge; next edge -> lost=0.
REQ-038 cnt=500, divide changed 624->99 -> cnt=0 and half toggles on the next cycle; no wrap through the maximum count.
REQ-039 SIG_DEGLITCH_EN defined, 2-cycle glitch on sig_in -> no capture; 3-cycle-stable rise -> capture at edge N+5.
